// File: rtl/axi_burst_read_master.sv
// AXI4 single-burst read initiator: AR issue, R collection, registered output stage.
// Optional rlast framing check is compiled in with `define AXI_RLAST_CHECK_EN.
module axi_burst_read_master #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STROBE_WIDTH  = DATA_WIDTH / 8,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     err_resp,
    output logic                     err_last
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]               arlen_q, arlen_d;
    logic [8:0]               beats_left_q, beats_left_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     done_q, done_d;
    logic                     err_resp_q, err_resp_d;
    logic                     err_last_q, err_last_d;
    logic                     r_hs;
    logic                     final_beat;
    logic                     rlast_mismatch;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign arvalid    = (state_q == ST_ADDR);
    // Only accept a beat when the output register is free or being drained this cycle.
    assign rready     = (state_q == ST_DATA) && (!out_valid_q || out_ready);
    assign r_hs       = rvalid && rready;
    assign final_beat = (beats_left_q == 9'd1);

`ifdef AXI_RLAST_CHECK_EN
    assign rlast_mismatch = (rlast != final_beat);
`else
    logic rlast_unused;
    assign rlast_unused   = rlast;
    assign rlast_mismatch = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        beats_left_d = beats_left_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        err_resp_d   = err_resp_q;
        err_last_d   = err_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    araddr_d     = cmd_addr;
                    arlen_d      = cmd_len;
                    beats_left_d = {1'b0, cmd_len} + 9'd1;
                    err_resp_d   = 1'b0;
                    err_last_d   = 1'b0;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    out_data_d   = rdata;
                    out_valid_d  = 1'b1;
                    out_last_d   = final_beat;
                    beats_left_d = beats_left_q - 9'd1;
                    if (rresp != 2'b00) begin
                        err_resp_d = 1'b1;
                    end
                    if (rlast_mismatch) begin
                        err_last_d = 1'b1;
                    end
                    if (final_beat) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            araddr_q     <= '0;
            arlen_q      <= '0;
            beats_left_q <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            err_resp_q   <= 1'b0;
            err_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            beats_left_q <= beats_left_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            err_resp_q   <= err_resp_d;
            err_last_q   <= err_last_d;
        end
    end

    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = 3'($clog2(STROBE_WIDTH));
    assign arburst   = 2'b01;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign err_resp  = err_resp_q;
    assign err_last  = err_last_q;

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Bench for axi_burst_read_master: behavioural slave plus transaction-level expectation model.
module tb_axi_burst_read_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        done;
    logic        err_resp;
    logic        err_last;

    axi_burst_read_master #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(8)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .done     (done),
        .err_resp (err_resp),
        .err_last (err_last)
    );

    always #5 aclk = ~aclk;

    int n_err = 0;
    int n_chk = 0;

    // Stimulus-owned slave/sink knobs
    logic [31:0] s_base = '0;
    int          s_err_idx = -1;
    int          s_last_idx = 0;
    logic        s_force = 1'b0;
    logic        or_level = 1'b1;
    logic        or_toggle = 1'b0;

    // Slave-driver-owned state
    logic s_active = 1'b0;
    int   s_idx = 0;

    // Compare-process-owned model
    logic [32:0] exp_q[$];
    logic [32:0] exp_beat;
    logic [7:0]  m_addr = '0;
    logic [7:0]  m_len = '0;
    logic        m_arvalid = 1'b0;
    logic        m_in_data = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err_resp = 1'b0;
    logic        m_err_last = 1'b0;
    logic        s_start = 1'b0;
    logic        s_adv = 1'b0;
    int          n_pop = 0;
    int          m_rcount = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectations are checked before the model is advanced for the coming edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            m_arvalid  = 1'b0;
            m_in_data  = 1'b0;
            m_done     = 1'b0;
            m_err_resp = 1'b0;
            m_err_last = 1'b0;
            s_start    = 1'b0;
            s_adv      = 1'b0;
        end else begin
            chk("arvalid", arvalid, m_arvalid);
            chk("cmd_ready", cmd_ready, !m_arvalid && !m_in_data);
            chk("done", done, m_done);
            chk("err_resp", err_resp, m_err_resp);
            chk("err_last", err_last, m_err_last);
            if (arvalid) begin
                chk("araddr_hold", araddr, m_addr);
                chk("arlen_hold", arlen, m_len);
                chk("ar_const", {arsize, arburst}, {3'd2, 2'b01});
            end
            chk("rready_idle", rready && !m_in_data, 0);
            chk("rready_bp", rready && out_valid && !out_ready, 0);
            if (m_in_data && or_level && !or_toggle) chk("no_bubble", rready, 1);
            if (out_valid && out_ready) begin
                chk("beat_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    n_pop++;
                    chk("beat", {out_last, out_data}, exp_beat);
                end
            end

            m_done  = 1'b0;
            s_start = arvalid && arready;
            s_adv   = rvalid && rready;
            if (cmd_valid && cmd_ready) begin
                m_arvalid  = 1'b1;
                m_addr     = cmd_addr;
                m_len      = cmd_len;
                m_err_resp = 1'b0;
                m_err_last = 1'b0;
                n_pop      = 0;
                m_rcount   = 0;
                for (int i = 0; i <= int'(cmd_len); i++)
                    exp_q.push_back({(i == int'(cmd_len)), s_base + 32'(i) * 32'h0101_0101});
            end
            if (arvalid && arready) begin
                m_arvalid = 1'b0;
                m_in_data = 1'b1;
            end
            if (rvalid && rready) begin
                m_rcount++;
                if (rresp != 2'b00) m_err_resp = 1'b1;
`ifdef AXI_RLAST_CHECK_EN
                if (rlast != (s_idx == int'(m_len))) m_err_last = 1'b1;
`endif
                if (s_idx == int'(m_len)) begin
                    m_done    = 1'b1;
                    m_in_data = 1'b0;
                end
            end
        end
    end

    // Behavioural R-channel slave and downstream sink
    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            s_active = 1'b0;
            s_idx    = 0;
        end else begin
            if (s_adv) begin
                s_idx++;
                if (s_idx > int'(m_len)) s_active = 1'b0;
            end
            if (s_start) begin
                s_active = 1'b1;
                s_idx    = 0;
            end
        end
        rvalid = s_active || s_force;
        rdata  = s_base + 32'(s_idx) * 32'h0101_0101;
        rresp  = (s_idx == s_err_idx) ? 2'b10 : 2'b00;
        rlast  = (s_idx == s_last_idx);
        if (or_toggle) out_ready = ~out_ready;
        else out_ready = or_level;
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] l, input int arwait, input int last_idx);
        int t = 0;
        s_last_idx = (last_idx < 0) ? int'(l) : last_idx;
        cmd_addr   = a;
        cmd_len    = l;
        cmd_valid  = 1'b1;
        arready    = 1'b0;
        while (!cmd_ready && t < 100) begin
            @(posedge aclk); #1;
            t++;
        end
        chk("cmd_accept_timeout", t < 100, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_len   = ~l;
        repeat (arwait) begin
            @(posedge aclk); #1;
        end
        arready = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || m_arvalid || m_in_data) && t < budget) begin
            @(negedge aclk);
            t++;
        end
        chk({name, "_complete"}, t < budget, 1);
        @(posedge aclk); #1;
    endtask

    initial begin
        int t;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_ctrl", {arvalid, rready, out_valid, out_last, done, err_resp, err_last, cmd_ready}, 8'b0000_0001);
        chk("rst_regs", {araddr, arlen, out_data}, 48'h0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // addr 0x10, len 3, arready held low 4 cycles
        s_base = 32'hA000_0000;
        issue(8'h10, 8'd3, 4, -1);
        chk("t1_araddr", araddr, 8'h10);
        chk("t1_arlen", arlen, 8'd3);
        wait_done("t1", 100);
        chk("t1_beats", n_pop, 4);

        // single beat
        s_base = 32'hDEAD_BEEF;
        issue(8'h44, 8'd0, 0, -1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge aclk);
            t++;
        end
        chk("t2_beat", {out_last, out_data}, 33'h1_DEAD_BEEF);
        chk("t2_done", done, 1);
        wait_done("t2", 50);

        // out_ready toggling each cycle
        s_base    = 32'h1100_0000;
        or_toggle = 1'b1;
        issue(8'h80, 8'd7, 1, -1);
        wait_done("t3", 200);
        chk("t3_beats", n_pop, 8);
        or_toggle = 1'b0;
        or_level  = 1'b1;

        // SLVERR on beat 2
        s_base    = 32'h2200_0000;
        s_err_idx = 1;
        issue(8'h20, 8'd3, 0, -1);
        wait_done("t4", 100);
        chk("t4_beats", n_pop, 4);
        chk("t4_err_resp", err_resp, 1);
        s_err_idx = -1;

        // rlast asserted early on beat 3; next accept must clear err_resp
        s_base = 32'h3300_0000;
        issue(8'h30, 8'd3, 0, 2);
        chk("t5_err_clear", err_resp, 0);
        wait_done("t5", 100);
        chk("t5_beats", n_pop, 4);
`ifdef AXI_RLAST_CHECK_EN
        chk("t5_err_last", err_last, 1);
`else
        chk("t5_err_last", err_last, 0);
`endif

        // 256-beat burst
        s_base = 32'h0000_0100;
        issue(8'hF0, 8'd255, 0, -1);
        wait_done("t6", 600);
        chk("t6_beats", n_pop, 256);

        // reset after 3 of 8 beats
        s_base = 32'h5500_0000;
        issue(8'h50, 8'd7, 0, -1);
        t = 0;
        while (m_rcount < 3 && t < 100) begin
            @(negedge aclk);
            t++;
        end
        chk("t7_reach3", t < 100, 1);
        @(posedge aclk); #2;
        aresetn = 1'b0;
        s_force = 1'b1;
        #1;
        chk("t7_rst_ctrl", {arvalid, rready, out_valid, out_last, done, err_resp, err_last, cmd_ready}, 8'b0000_0001);
        chk("t7_rst_regs", {araddr, arlen, out_data}, 48'h0);
        @(posedge aclk); #3;
        aresetn = 1'b1;
        repeat (6) @(negedge aclk);
        chk("t7_ignored", {out_valid, rready, cmd_ready}, 3'b001);
        @(posedge aclk); #1;
        s_force = 1'b0;
        repeat (3) @(posedge aclk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
